// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// One division in flight; result_o = {remainder, quotient}, held while start_i stays high.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_BY_ZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  // {rem, quo}; the extra top bit of the partial remainder only ever exists
  // transiently in rem_shift, so it is not stored.
  logic [2*WIDTH-1:0] pr_reg, pr_next;
  logic [WIDTH-1:0]   divisor_reg, divisor_next;
  logic               sign1_reg, sign1_next;
  logic               sign2_reg, sign2_next;
  logic               mode_reg, mode_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic               ready_reg, ready_next;

  logic               accept;
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     rem_shift;
  logic               trial_ge;
  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;
  logic               cnt_done;

  assign accept    = start_i && !annul_i;
  assign op1_neg   = signed_div_i && opdata1_i[WIDTH-1];
  assign op2_neg   = signed_div_i && opdata2_i[WIDTH-1];
  assign abs1      = op1_neg ? -opdata1_i : opdata1_i;
  assign abs2      = op2_neg ? -opdata2_i : opdata2_i;

  assign quo_raw   = pr_reg[WIDTH-1:0];
  assign rem_raw   = pr_reg[2*WIDTH-1:WIDTH];
  assign rem_shift = pr_reg[2*WIDTH-1:WIDTH-1];
  assign trial_ge  = rem_shift >= {1'b0, divisor_reg};
  assign trial     = rem_shift[WIDTH-1:0] - divisor_reg;
  assign cnt_done  = (cnt_reg == CNT_W'(WIDTH));

  // Negation is mod 2^WIDTH, so the most-negative / -1 case wraps onto itself.
  assign quo_fix   = (mode_reg && (sign1_reg ^ sign2_reg)) ? -quo_raw : quo_raw;
  assign rem_fix   = (mode_reg && sign1_reg) ? -rem_raw : rem_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FREE;
      cnt_reg     <= '0;
      pr_reg      <= '0;
      divisor_reg <= '0;
      sign1_reg   <= 1'b0;
      sign2_reg   <= 1'b0;
      mode_reg    <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pr_reg      <= pr_next;
      divisor_reg <= divisor_next;
      sign1_reg   <= sign1_next;
      sign2_reg   <= sign2_next;
      mode_reg    <= mode_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FREE: begin
        if (accept) begin
          state_next = (opdata2_i == '0) ? ST_BY_ZERO : ST_ON;
        end
      end
      ST_BY_ZERO: state_next = annul_i ? ST_FREE : ST_END;
      ST_ON: begin
        if (annul_i) begin
          state_next = ST_FREE;
        end else if (cnt_done) begin
          state_next = ST_END;
        end
      end
      ST_END:  state_next = start_i ? ST_END : ST_FREE;
      default: state_next = ST_FREE;
    endcase
  end

  always_comb begin
    cnt_next     = cnt_reg;
    pr_next      = pr_reg;
    divisor_next = divisor_reg;
    sign1_next   = sign1_reg;
    sign2_next   = sign2_reg;
    mode_next    = mode_reg;
    result_next  = '0;
    ready_next   = 1'b0;
    case (state_reg)
      ST_FREE: begin
        if (accept) begin
          cnt_next = '0;
          if (opdata2_i != '0) begin
            pr_next      = {{WIDTH{1'b0}}, abs1};
            divisor_next = abs2;
            sign1_next   = op1_neg;
            sign2_next   = op2_neg;
            mode_next    = signed_div_i;
          end
        end
      end
      ST_ON: begin
        if (!annul_i) begin
          if (!cnt_done) begin
            pr_next  = trial_ge ? {trial, quo_raw[WIDTH-2:0], 1'b1}
                                : {rem_shift[WIDTH-1:0], quo_raw[WIDTH-2:0], 1'b0};
            cnt_next = cnt_reg + CNT_W'(1);
          end else begin
            result_next = {rem_fix, quo_fix};
            ready_next  = 1'b1;
          end
        end
      end
      // Zero-divisor path enters END with ready low and raises it one edge later.
      ST_END: begin
        if (start_i) begin
          result_next = result_reg;
          ready_next  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// divisions compared against plain-arithmetic quotient/remainder.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_chk = 0;
  int n_bad = 0;
  int hi_cnt;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on 64-bit integers, keeping the low 32 bits.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int lat;
    int want;
    exp  = model(sgn, a, b);
    want = (b == 32'd0) ? 2 : 33;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    // operands are latched at acceptance, so later changes must not matter
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    while (!ready_o && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("div %s sgn=%0d a=%h b=%h res=%h lat=%0d", tag, sgn, a, b, result_o, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(want));
    chk({tag, "_res"}, result_o, exp);
    annul_i = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_res"}, result_o, exp);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_free_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_free_res"}, result_o, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit          s;
    int          sel;
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(ready_o), 64'd0);
    chk("rst_res", result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(1'b0, 32'd100, 32'd7, "u100_7");
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, "s-7_2");
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, "s7_-2");
    run_div(1'b0, 32'd5, 32'd0, "u5_0");
    run_div(1'b1, 32'd5, 32'd0, "s5_0");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "smin_-1");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, "umax_1");
    run_div(1'b1, 32'd0, 32'd9, "s0_9");

    // annul mid-division: back to FREE, no result
    signed_div_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_rdy", 64'(ready_o), 64'd0);
    chk("annul_res", result_o, 64'd0);
    hi_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) hi_cnt++;
    end
    chk("annul_never_rdy", 64'(hi_cnt), 64'd0);
    run_div(1'b0, 32'd20, 32'd3, "u20_3");

    // annul held in FREE blocks acceptance
    opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    hi_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) hi_cnt++;
    end
    chk("annul_free_block", 64'(hi_cnt), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    @(posedge clk); #1;

    // reset mid-division discards the operation
    opdata1_i = 32'd20; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (13) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_rdy", 64'(ready_o), 64'd0);
    chk("midrst_res", result_o, 64'd0);
    hi_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) hi_cnt++;
    end
    chk("midrst_never_rdy", 64'(hi_cnt), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, "u9_3");

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'd0;
        3: a = 32'h80000000;
        4: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_div(s, a, b, "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
